// File: rtl/param_big_alu_if.sv
// param_big_alu_if -- operand/function-code/result bundle for param_big_alu.
// The master side drives the operation request and the slave (the ALU)
// returns the registered result together with its busy/done status.
interface param_big_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       signal;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output a, output b, output signal,
                  input result, input busy, input done);
  modport slave  (input a, input b, input signal,
                  output result, output busy, output done);
endinterface

// File: rtl/param_big_alu.sv
// param_big_alu -- parameterised ALU with single-cycle logic/arith/shift ops
// and a multi-cycle unsigned multiplier (shift-add, one bit per cycle) that
// writes its double-width product into HI/LO.
// Optional feature macro: ALU_DIVU_EN adds unsigned restoring division on
// code 27 (LO = quotient, HI = remainder). Without it code 27 is unknown.
module param_big_alu #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            reset,
  param_big_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] OP_SLL   = 6'd0;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIVU  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_LO    = 6'd60;
  localparam logic [5:0] OP_HI    = 6'd61;

`ifdef ALU_DIVU_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd3} state_t;
`endif

  state_t             state;
  logic [2*WIDTH-1:0] acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mcand;   // latched multiplicand or divisor
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign bus.result = result;
  assign bus.busy   = busy;
  assign bus.done   = done;

  // Single-cycle function decode; unknown codes produce zero.
  always_comb begin
    alu_out = '0;
    case (bus.signal)
      OP_SLL:  alu_out = bus.a << bus.b[SW-1:0];
      OP_SRL:  alu_out = bus.a >> bus.b[SW-1:0];
      OP_ADD:  alu_out = bus.a + bus.b;
      OP_SUB:  alu_out = bus.a - bus.b;
      OP_AND:  alu_out = bus.a & bus.b;
      OP_OR:   alu_out = bus.a | bus.b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_LO:   alu_out = lo;
      OP_HI:   alu_out = hi;
      default: alu_out = '0;
    endcase
  end

  // One shift-add step: add multiplicand to upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef ALU_DIVU_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  // One restoring-division step: bring the next dividend bit into the
  // remainder and subtract the divisor when it fits. A zero divisor always
  // fits, which naturally yields an all-ones quotient and remainder = a.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
  end
`endif

  // Control FSM with registered result, HI/LO and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          cnt  <= '0;
          if (bus.signal == OP_MULTU) begin
            state <= MUL;
            acc   <= {{WIDTH{1'b0}}, bus.b};
            mcand <= bus.a;
            busy  <= 1'b1;
`ifdef ALU_DIVU_EN
          end else if (bus.signal == OP_DIVU) begin
            state <= DIV;
            acc   <= {{WIDTH{1'b0}}, bus.a};
            mcand <= bus.b;
            busy  <= 1'b1;
`endif
          end else begin
            result <= alu_out;
            busy   <= 1'b0;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            done  <= 1'b0;
          end
        end
`ifdef ALU_DIVU_EN
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            done  <= 1'b0;
          end
        end
`endif
        FIN: begin
          hi    <= acc[2*WIDTH-1:WIDTH];
          lo    <= acc[WIDTH-1:0];
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_big_alu.sv
// tb_param_big_alu -- scoreboard bench: stimulus pushes the expected
// post-edge outputs computed by a plain-arithmetic model; a monitor pops and
// compares one entry per clock. A second WIDTH=8 instance gets directed checks.
module tb_param_big_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  param_big_alu_if #(.WIDTH(W)) bus ();
  param_big_alu_if #(.WIDTH(8)) bus8 ();

  param_big_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  param_big_alu #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: architectural values plus remaining busy cycles.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_res = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_rem = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs one step after each active edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("result", bus.result, e.res);
      chk("busy", bus.busy, e.busy);
      chk("done", bus.done, e.done);
    end
  end

  // Drive one operation for the next edge and record the expected outcome.
  task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit release_rst = 1'b0);
    exp_t e;
    @(negedge clk);
    if (release_rst) reset = 1'b1;
    bus.signal = op;
    bus.a = a;
    bus.b = b;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) {m_hi, m_lo} = m_pend;
    end else begin
      case (op)
        6'd0:  m_res = a << (b % 32);
        6'd2:  m_res = a >> (b % 32);
        6'd25: begin m_pend = {32'd0, a} * {32'd0, b}; m_rem = W + 1; end
`ifdef ALU_DIVU_EN
        6'd27: begin
          if (b == 32'd0) m_pend = {a, 32'hFFFF_FFFF};
          else            m_pend = {a % b, a / b};
          m_rem = W + 1;
        end
`endif
        6'd32: m_res = a + b;
        6'd34: m_res = a - b;
        6'd36: m_res = a & b;
        6'd37: m_res = a | b;
        6'd42: m_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'd60: m_res = m_lo;
        6'd61: m_res = m_hi;
        default: m_res = 32'd0;
      endcase
    end
    e.res = m_res;
    e.busy = (m_rem > 0);
    e.done = (m_rem == 1);
    sbq.push_back(e);
  endtask

  logic [5:0] ops [12] = '{6'd0, 6'd2, 6'd25, 6'd27, 6'd32, 6'd34, 6'd36,
                           6'd37, 6'd42, 6'd60, 6'd61, 6'd63};

  task automatic filler(input int n);
    for (int i = 0; i < n; i++)
      step(ops[$urandom_range(0, 11)], $urandom, $urandom);
  endtask

  initial begin
    bus.signal = 6'd63; bus.a = 32'd0; bus.b = 32'd0;
    bus8.signal = 6'd63; bus8.a = 8'd0; bus8.b = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);

    // Directed single-cycle vectors; first op released with reset.
    step(6'd32, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step(6'd34, 32'd0, 32'd1);
    step(6'd42, 32'hFFFF_FFFF, 32'd1);
    step(6'd42, 32'd1, 32'hFFFF_FFFF);
    step(6'd0, 32'd1, 32'd35);
    step(6'd2, 32'h8000_0000, 32'd31);
    step(6'd63, 32'd5, 32'd5);
    step(6'd36, 32'hF0F0_1234, 32'h0FF0_FFFF);
    step(6'd37, 32'hF000_0000, 32'h0000_000F);

    // Max multiply; ADDs while busy must not disturb anything.
    step(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < W + 1; i++) step(6'd32, 32'd7, 32'd9);
    step(6'd61, 32'd0, 32'd0);
    step(6'd60, 32'd0, 32'd0);

    // Division (or unknown code when the divider is not built).
    step(6'd27, 32'd100, 32'd7);
    filler(W + 1);
    step(6'd60, 32'd0, 32'd0);
    step(6'd61, 32'd0, 32'd0);
    step(6'd27, 32'd5, 32'd0);
    filler(W + 1);
    step(6'd60, 32'd0, 32'd0);
    step(6'd61, 32'd0, 32'd0);

    // Reset ten cycles into MULTU 3x4.
    step(6'd25, 32'd3, 32'd4);
    filler(10);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0; m_rem = 0;
    step(6'd61, 32'd0, 32'd0, 1'b1);
    step(6'd60, 32'd0, 32'd0);
    step(6'd25, 32'd3, 32'd4);
    filler(W + 1);
    step(6'd60, 32'd0, 32'd0);
    step(6'd61, 32'd0, 32'd0);

    // Randomised mix against the model.
    filler(400);
    step(6'd60, 32'd0, 32'd0);
    step(6'd61, 32'd0, 32'd0);
    // Let any pending multi-cycle op finish before the small instance runs.
    filler(W + 2);
    repeat (2) @(negedge clk);

    // WIDTH=8 instance: MULTU 0xFF x 0xFF, busy 9 cycles, then HI/LO, SLL.
    bus8.signal = 6'd25; bus8.a = 8'hFF; bus8.b = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk("w8_busy", bus8.busy, 1'b1);
      chk("w8_done", bus8.done, (i == 8) ? 1'b1 : 1'b0);
      if (i == 0) begin bus8.signal = 6'd32; bus8.a = 8'd1; bus8.b = 8'd1; end
    end
    @(posedge clk);
    #1;
    chk("w8_busy_end", bus8.busy, 1'b0);
    chk("w8_done_end", bus8.done, 1'b0);
    @(negedge clk);
    bus8.signal = 6'd61;
    @(posedge clk);
    #1;
    chk("w8_hi", bus8.result, 8'hFE);
    @(negedge clk);
    bus8.signal = 6'd60;
    @(posedge clk);
    #1;
    chk("w8_lo", bus8.result, 8'h01);
    @(negedge clk);
    bus8.signal = 6'd0; bus8.a = 8'd1; bus8.b = 8'd9;
    @(posedge clk);
    #1;
    chk("w8_sll", bus8.result, 8'd2);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_big_alu.md
PARAM_BIG_ALU -- requirements
Module: param_big_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, result, HI and LO width; legal values are 8 to 64 and powers of two.
REQ-002 Parameter SW, default log2(WIDTH), SHALL set the number of low bits of b used as the shift amount.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 a  input  WIDTH  SHALL be operand A (shift source for SRL/SLL).
REQ-006 b  input  WIDTH  SHALL be operand B (shift amount in b[SW-1:0]).
REQ-007 signal  input  6  SHALL be the function code: SLL=0, SRL=2, MULTU=25, DIVU=27, ADD=32, SUB=34, AND=36, OR=37, SLT=42, LO=60, HI=61.
REQ-008 result  output  WIDTH  SHALL be the registered result.
REQ-009 busy  output  1  SHALL be high while a MULTU or DIVU is iterating.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when HI/LO are updated.

Function
REQ-011 Single-cycle ops (AND, OR, ADD, SUB, SLT, SRL, SLL, HI, LO) SHALL be sampled on a rising edge with busy=0, and result SHALL show the value after that edge (latency 1).
REQ-012 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow detection.
REQ-013 SLT SHALL compare a and b as two's-complement numbers and return 1 if a<b, else 0 (zero-extended).
REQ-014 SRL/SLL SHALL be logical shifts of a by b[SW-1:0]; upper bits of b are ignored.
REQ-015 HI/LO codes SHALL load result with the HI/LO register contents.
REQ-016 Unknown codes SHALL load result with 0.
REQ-017 The FSM SHALL have states IDLE, MUL, DIV, FIN.
REQ-018 Transitions SHALL be: IDLE->MUL on MULTU; IDLE->DIV on DIVU; MUL/DIV->FIN after WIDTH iteration cycles; FIN->IDLE unconditionally.
REQ-019 MULTU SHALL be unsigned shift-add, one bit per cycle, and SHALL latch a and b on the start edge.
REQ-020 busy SHALL be high in MUL, DIV and FIN; done SHALL be high in FIN only.
REQ-021 The full 2*WIDTH-bit product SHALL be written to {HI,LO} on the FIN edge (WIDTH+1 cycles after the start edge).
REQ-022 While busy=1, signal, a and b SHALL be ignored; a new MULTU/DIVU is not queued.
REQ-023 result SHALL hold its last value while busy=1.
REQ-024 HI and LO SHALL change only at FIN or on reset.

Reset
REQ-025 reset=0 SHALL immediately force the FSM to IDLE and clear result, HI, LO, busy, done and the iteration counter, including mid-operation, with no write to HI/LO.
REQ-026 The first operation SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-027 Macro ALU_DIVU_EN SHALL compile in unsigned restoring division on code 27 (DIV state, WIDTH cycles, LO=quotient, HI=remainder).
REQ-028 With ALU_DIVU_EN, divide-by-zero SHALL still take WIDTH+1 cycles and give LO=all ones and HI=a.
REQ-029 Without ALU_DIVU_EN, the DIV state SHALL be absent and code 27 SHALL act as an unknown code (result=0, busy stays 0).

Verification
REQ-030 ADD a=0xFFFFFFFF b=1 -> result=0x00000000 one cycle later; SUB a=0 b=1 -> 0xFFFFFFFF.
REQ-031 SLT a=0xFFFFFFFF b=1 -> 1; SLT a=1 b=0xFFFFFFFF -> 0; SLL a=1 b=35 -> 8; SRL a=0x80000000 b=31 -> 1.
REQ-032 MULTU a=b=0xFFFFFFFF -> busy for 33 cycles, done pulse in cycle 33, then HI code gives 0xFFFFFFFE and LO code gives 0x00000001; ADD issued while busy has no effect.
REQ-033 DIVU (with ALU_DIVU_EN) a=100 b=7 -> LO=14, HI=2; a=5 b=0 -> LO=0xFFFFFFFF, HI=5.
REQ-034 Assert reset=0 ten cycles into MULTU 3x4 -> busy=0, done=0, HI=LO=result=0 immediately; after release, a new MULTU 3x4 gives LO=12, HI=0.
REQ-035 Run with WIDTH=8: MULTU 0xFF x 0xFF -> HI=0xFE, LO=0x01 after 9 cycles; SLL a=1 b=9 -> 2.
